// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// States, requester ids and the default poison read value.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_e;

    typedef enum logic {
        PORT_INSTR,
        PORT_DATA
    } port_id_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/MemPort.sv
// Core-side memory port bundle.
// The master drives a request, the slave returns ready and rdata.
interface MemPort;

    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        write_en;
    logic [3:0]  byte_en;
    logic [31:0] wdata;

    modport Master (
        output valid, addr, write_en, byte_en, wdata,
        input  ready, rdata
    );

    modport Slave (
        input  valid, addr, write_en, byte_en, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: bit 0 is instr, bit 1 is data.
// On a granted update the pointer moves to the loser.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_e   ptr,
    input  logic       update,
    output logic [1:0] grant,
    output port_id_e   ptr_next
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr == PORT_INSTR) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        ptr_next = ptr;
        if (update && (grant != 2'b00)) begin
            ptr_next = grant[0] ? PORT_DATA : PORT_INSTR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges instr and data MemPorts onto one variable-latency bus,
// one transaction at a time, with a poisoning watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    MemPort.Slave       instr_port,
    MemPort.Slave       data_port,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1
                      : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    arb_state_e    state;
    arb_state_e    state_next;
    port_id_e      winner;
    port_id_e      rr_ptr;
    port_id_e      rr_ptr_next;
    logic [1:0]    req_vec;
    logic [1:0]    grant;
    logic          start;
    logic [CW-1:0] wd_cnt;
    logic [CW-1:0] wd_inc;
    logic          wd_expire;
    logic [31:0]   rdata_q;

    assign req_vec = {data_port.valid, instr_port.valid};
    assign start   = (state == IDLE) && (req_vec != 2'b00);

    rr_arbiter_2 u_rr (
        .req      (req_vec),
        .ptr      (rr_ptr),
        .update   (start),
        .grant    (grant),
        .ptr_next (rr_ptr_next)
    );

    // Saturating count; expiry fires on the WAIT cycle that reaches the limit
    assign wd_inc    = (wd_cnt == {CW{1'b1}}) ? wd_cnt : wd_cnt + 1'b1;
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_inc == CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (req_vec != 2'b00) state_next = ISSUE;
            ISSUE: if (bus_gnt) state_next = WAIT;
            WAIT:  if (bus_rvalid || wd_expire) state_next = ACK;
            ACK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_req          = (state == ISSUE);
        instr_port.ready = (state == ACK) && (winner == PORT_INSTR);
        data_port.ready  = (state == ACK) && (winner == PORT_DATA);
        instr_port.rdata = rdata_q;
        data_port.rdata  = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner          <= PORT_INSTR;
            rr_ptr          <= PORT_INSTR;
            bus_addr        <= '0;
            bus_we          <= 1'b0;
            bus_be          <= '0;
            bus_wdata       <= '0;
            wd_cnt          <= '0;
            rdata_q         <= '0;
            bus_timeout_err <= 1'b0;
        end else begin
            rr_ptr <= rr_ptr_next;
            unique case (state)
                IDLE: begin
                    if (req_vec != 2'b00) begin
                        if (grant[1]) begin
                            winner    <= PORT_DATA;
                            bus_addr  <= data_port.addr;
                            bus_we    <= data_port.write_en;
                            bus_be    <= data_port.byte_en;
                            bus_wdata <= data_port.wdata;
                        end else begin
                            winner    <= PORT_INSTR;
                            bus_addr  <= instr_port.addr;
                            bus_we    <= instr_port.write_en;
                            bus_be    <= instr_port.byte_en;
                            bus_wdata <= instr_port.wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (bus_gnt) wd_cnt <= '0;
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        rdata_q <= bus_rdata;
                    end else begin
                        wd_cnt <= wd_inc;
                        if (wd_expire) begin
                            rdata_q         <= ERR_RDATA;
                            bus_timeout_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a delay-configurable
// bus responder and TIMEOUT_CYCLES = 8.
module tb_mem_port_arbiter;

    typedef struct {
        int          port;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_timeout_err;

    MemPort instr_if ();
    MemPort data_if ();

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_port      (instr_if),
        .data_port       (data_if),
        .bus_req         (bus_req),
        .bus_gnt         (bus_gnt),
        .bus_addr        (bus_addr),
        .bus_we          (bus_we),
        .bus_be          (bus_be),
        .bus_wdata       (bus_wdata),
        .bus_rvalid      (bus_rvalid),
        .bus_rdata       (bus_rdata),
        .bus_timeout_err (bus_timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    exp_t        sb[$];
    logic [31:0] gnt_log[$];
    int          rdy_cnt      = 0;
    int          data_rdy_cnt = 0;
    int          last_rdy_cyc = 0;
    int          req_cnt      = 0;
    bit          pend         = 1'b0;
    logic [31:0] pend_rd      = '0;

    int          gnt_delay = 0;
    int          rv_delay  = 1;
    bit          mute      = 1'b0;
    int          bm_ph     = 0;
    int          bm_cnt    = 0;
    logic [31:0] bm_addr   = '0;
    logic        bm_we     = 1'b0;
    logic [3:0]  bm_be     = '0;
    logic [31:0] bm_wdata  = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a == 32'h1000_0000) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: grants after gnt_delay, responds rv_delay after grant
    always @(negedge clk) begin
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        case (bm_ph)
            0: if (bus_req) begin
                bm_addr  = bus_addr;
                bm_we    = bus_we;
                bm_be    = bus_be;
                bm_wdata = bus_wdata;
                if (gnt_delay == 0) begin
                    bus_gnt = 1'b1;
                    gnt_log.push_back(bus_addr);
                    bm_cnt = rv_delay;
                    bm_ph  = 2;
                end else begin
                    bm_cnt = gnt_delay;
                    bm_ph  = 1;
                end
            end
            1: begin
                chk("req_held", {31'd0, bus_req}, 32'd1);
                chk("req_addr_stable", bus_addr, bm_addr);
                chk("req_wdata_stable", bus_wdata, bm_wdata);
                chk("req_ctl_stable", {27'd0, bus_we, bus_be},
                    {27'd0, bm_we, bm_be});
                bm_cnt--;
                if (bm_cnt == 0) begin
                    bus_gnt = 1'b1;
                    gnt_log.push_back(bus_addr);
                    bm_cnt = rv_delay;
                    bm_ph  = 2;
                end
            end
            2: if (!mute) begin
                bm_cnt--;
                if (bm_cnt <= 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = exp_rd(bm_addr);
                    bm_ph      = 0;
                end
            end
            default: bm_ph = 0;
        endcase
    end

    // Output monitor: pops the scoreboard on each ready pulse
    always @(negedge clk) begin
        if (bus_req) req_cnt++;
        if (pend) begin
            chk("rdata_instr", instr_if.rdata, pend_rd);
            chk("rdata_data", data_if.rdata, pend_rd);
            pend = 1'b0;
        end
        if (instr_if.ready || data_if.ready) begin
            rdy_cnt++;
            last_rdy_cyc = cyc;
            if (data_if.ready) data_rdy_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_ready",
                    {30'd0, data_if.ready, instr_if.ready}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_port",
                    {30'd0, data_if.ready, instr_if.ready},
                    (e.port == 1) ? 32'd2 : 32'd1);
                pend    = 1'b1;
                pend_rd = e.rd;
            end
        end
    end

    task automatic wait_rdy(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (rdy_cnt >= target) return;
        end
        chk("ready_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drive(input int port, input logic [31:0] a,
                         input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
        if (port == 0) begin
            instr_if.valid    = 1'b1;
            instr_if.addr     = a;
            instr_if.write_en = we;
            instr_if.byte_en  = be;
            instr_if.wdata    = wd;
        end else begin
            data_if.valid    = 1'b1;
            data_if.addr     = a;
            data_if.write_en = we;
            data_if.byte_en  = be;
            data_if.wdata    = wd;
        end
    endtask

    initial begin
        int c0;
        int base;
        int r0;
        instr_if.valid    = 1'b0;
        instr_if.addr     = '0;
        instr_if.write_en = 1'b0;
        instr_if.byte_en  = '0;
        instr_if.wdata    = '0;
        data_if.valid     = 1'b0;
        data_if.addr      = '0;
        data_if.write_en  = 1'b0;
        data_if.byte_en   = '0;
        data_if.wdata     = '0;

        do_reset();
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_we_be", {27'd0, bus_we, bus_be}, 32'd0);
        chk("rst_ready",
            {30'd0, data_if.ready, instr_if.ready}, 32'd0);
        chk("rst_rdata", instr_if.rdata, 32'd0);
        chk("rst_err", {31'd0, bus_timeout_err}, 32'd0);

        // Single instruction read, minimum latency
        c0 = cyc;
        drive(0, 32'h1000_0000, 1'b0, 4'hF, 32'd0);
        sb.push_back('{0, 32'h0000_0013});
        wait_rdy(1, 20);
        instr_if.valid = 1'b0;
        chk("read_latency", last_rdy_cyc - c0, 32'd3);
        chk("read_no_data_ready", data_rdy_cnt, 32'd0);
        step();

        // Both ports always valid: grants alternate from instr
        do_reset();
        base = gnt_log.size();
        r0   = rdy_cnt;
        drive(0, 32'h1000_0100, 1'b0, 4'hF, 32'd0);
        drive(1, 32'h2000_0200, 1'b0, 4'hF, 32'd0);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{0, exp_rd(32'h1000_0100)});
            sb.push_back('{1, exp_rd(32'h2000_0200)});
        end
        wait_rdy(r0 + 4, 40);
        instr_if.valid = 1'b0;
        data_if.valid  = 1'b0;
        step();
        chk("rr_count", gnt_log.size() - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < gnt_log.size())
                chk("rr_order", gnt_log[base+i],
                    (i % 2 == 0) ? 32'h1000_0100 : 32'h2000_0200);
        end

        // Data write with a 3-cycle grant delay
        gnt_delay = 3;
        r0        = rdy_cnt;
        req_cnt   = 0;
        drive(1, 32'h2000_0004, 1'b1, 4'b0011, 32'hA5A5_1234);
        sb.push_back('{1, exp_rd(32'h2000_0004)});
        wait_rdy(r0 + 1, 30);
        data_if.valid = 1'b0;
        chk("wr_req_cycles", req_cnt, 32'd4);
        chk("wr_addr", bus_addr, 32'h2000_0004);
        chk("wr_wdata", bus_wdata, 32'hA5A5_1234);
        chk("wr_we_be", {27'd0, bus_we, bus_be}, {27'd0, 1'b1, 4'b0011});
        gnt_delay = 0;
        step();

        // Response lands in the same cycle the watchdog expires
        rv_delay = 8;
        r0       = rdy_cnt;
        c0       = cyc;
        drive(0, 32'h1000_0040, 1'b0, 4'hF, 32'd0);
        sb.push_back('{0, exp_rd(32'h1000_0040)});
        wait_rdy(r0 + 1, 30);
        instr_if.valid = 1'b0;
        chk("edge_latency", last_rdy_cyc - c0, 32'd10);
        step();
        chk("edge_no_err", {31'd0, bus_timeout_err}, 32'd0);
        rv_delay = 1;

        // Bus never responds: watchdog poisons and sets sticky error
        mute = 1'b1;
        r0   = rdy_cnt;
        c0   = cyc;
        drive(1, 32'h2000_0300, 1'b0, 4'hF, 32'd0);
        sb.push_back('{1, 32'hDEAD_BEEF});
        wait_rdy(r0 + 1, 30);
        data_if.valid = 1'b0;
        chk("to_latency", last_rdy_cyc - c0, 32'd10);
        step();
        chk("to_err", {31'd0, bus_timeout_err}, 32'd1);
        mute = 1'b0;
        r0   = rdy_cnt;
        for (int i = 0; i < 4; i++) step();
        chk("to_late_rvalid_ignored", rdy_cnt - r0, 32'd0);
        chk("to_err_sticky", {31'd0, bus_timeout_err}, 32'd1);
        chk("to_rdata_held", data_if.rdata, 32'hDEAD_BEEF);

        // Reset while waiting on the bus drops the transaction
        mute = 1'b1;
        base = gnt_log.size();
        r0   = rdy_cnt;
        drive(0, 32'h1000_0080, 1'b0, 4'hF, 32'd0);
        for (int i = 0; i < 20 && gnt_log.size() == base; i++) step();
        chk("rw_granted", gnt_log.size() - base, 32'd1);
        step();
        instr_if.valid = 1'b0;
        rst            = 1'b1;
        step();
        chk("rw_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rw_bus_addr", bus_addr, 32'd0);
        chk("rw_ready",
            {30'd0, data_if.ready, instr_if.ready}, 32'd0);
        chk("rw_err", {31'd0, bus_timeout_err}, 32'd0);
        chk("rw_rdata", instr_if.rdata, 32'd0);
        rst  = 1'b0;
        mute = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("rw_stray_no_ready", rdy_cnt - r0, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks want completion", n_chk);
        $fatal(1, "bench did not complete");
    end

endmodule
